pc_source_ctrl: RTL and testbench
=================================

PC_SOURCE_CTRL -- requirements
Module: pc_source_ctrl

Interface
REQ-001 Parameter MEM_WAIT, default 1, number of wait cycles before the exception-vector word is valid at mux input 5; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 instr_valid  input  1  one-cycle strobe: op_class, alu_zero, overflow and opcode_invalid are valid for the current instruction.
REQ-005 op_class  input  3  000 sequential, 001 beq, 010 bne, 011 jump, 100 jump-register, 101 return-from-exception; 110/111 are treated as invalid.
REQ-006 alu_zero  input  1  ALU zero flag, sampled with instr_valid.
REQ-007 overflow  input  1  ALU arithmetic overflow, sampled with instr_valid.
REQ-008 opcode_invalid  input  1  decoder flags an unknown opcode, sampled with instr_valid.
REQ-009 pc_source  output  3  PC mux select: 0 PC+4, 1 branch target, 2 jump target, 3 register, 4 EPC, 5 exception vector.
REQ-010 pc_write  output  1  PC register load strobe, one cycle.
REQ-011 epc_write  output  1  EPC load strobe, one cycle.
REQ-012 cause_write  output  1  cause register load strobe, one cycle.
REQ-013 cause  output  2  00 invalid opcode, 01 overflow; valid while cause_write=1.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse in the cycle the PC update completes.

Function
REQ-016 FSM states: IDLE, UPDATE, EXC_SAVE, EXC_WAIT, EXC_LOAD.
REQ-017 IDLE with instr_valid=1 samples all inputs into registers; next state is EXC_SAVE on an exception, otherwise UPDATE.
REQ-018 Exception means opcode_invalid=1, op_class 110/111, or overflow=1; invalid takes priority over overflow (cause 00 over 01).
REQ-019 UPDATE (1 cycle): pc_source per class (000->0, 001/010->1, 011->2, 100->3, 101->4); done=1; next IDLE.
REQ-020 UPDATE pc_write=1 for classes 000, 011, 100 and 101; beq only if latched alu_zero=1; bne only if latched alu_zero=0; untaken branch gives pc_write=0 with done=1.
REQ-021 Normal latency: instr_valid in cycle N -> pc_write/done in cycle N+1.
REQ-022 EXC_SAVE (1 cycle): epc_write=1, cause_write=1, cause driven; wait counter loaded with MEM_WAIT; next EXC_WAIT.
REQ-023 EXC_WAIT decrements the counter each cycle and exits to EXC_LOAD when it reaches 1.
REQ-024 EXC_LOAD (1 cycle): pc_source=5, pc_write=1, done=1; next IDLE.
REQ-025 Exception latency: instr_valid in cycle N -> epc_write in N+1 -> pc_write/done in N+2+MEM_WAIT.
REQ-026 instr_valid while busy=1 is ignored; no queuing.
REQ-027 Outside the states named above, pc_source holds its last value and all strobes are 0.

Reset
REQ-028 reset_n=0 forces IDLE immediately, including mid-exception, and discards all latched inputs and counter state.
REQ-029 Reset values: pc_source=0, pc_write=0, epc_write=0, cause_write=0, cause=00, busy=0, done=0.
REQ-030 The first instr_valid accepted is the one in the first clk edge after reset_n rises.

Configuration
REQ-031 With macro PC_SOURCE_CTRL_EXC_EN defined, exception detection and states EXC_SAVE, EXC_WAIT and EXC_LOAD are present as specified.
REQ-032 Without PC_SOURCE_CTRL_EXC_EN: overflow and opcode_invalid are ignored; classes 101/110/111 behave as class 000; epc_write, cause_write and cause are tied to 0; exception states are not built.

Verification
REQ-033 Reset, then class 000 strobe -> next cycle pc_source=0, pc_write=1, done=1, busy=1; following cycle busy=0.
REQ-034 beq with alu_zero=1 -> pc_write=1, pc_source=1; beq with alu_zero=0 -> pc_write=0, done=1; bne gives the inverse results.
REQ-035 MEM_WAIT=3: overflow=1 with class 000 at cycle 0 -> epc_write=1 and cause=01 at cycle 1; pc_write=1 with pc_source=5 at cycle 5.
REQ-036 opcode_invalid=1 and overflow=1 together -> cause=00; instr_valid pulses during EXC_WAIT produce no extra strobes.
REQ-037 reset_n driven low asynchronously during EXC_WAIT -> all outputs 0 at once; a class 011 strobe after release -> pc_source=2, pc_write=1 one cycle later.

Source files
------------

// File: rtl/pc_source_ctrl.sv
// PC source / exception sequencing controller: turns one instruction strobe into PC mux select and load strobes.
// Exception handling (EPC/cause save, vector fetch wait) is built only when PC_SOURCE_CTRL_EXC_EN is defined.
module pc_source_ctrl #(
   parameter int MEM_WAIT = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       instr_valid,
   input  logic [2:0] op_class,
   input  logic       alu_zero,
   input  logic       overflow,
   input  logic       opcode_invalid,
   output logic [2:0] pc_source,
   output logic       pc_write,
   output logic       epc_write,
   output logic       cause_write,
   output logic [1:0] cause,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE,
`ifdef PC_SOURCE_CTRL_EXC_EN
      EXC_SAVE,
      EXC_WAIT,
      EXC_LOAD,
`endif
      UPDATE
   } state_t;

   state_t     state_reg, state_next;
   logic [2:0] class_reg;
   logic       zero_reg;
   logic [2:0] src_reg;
   logic [2:0] upd_src;
   logic       upd_pcw;

`ifdef PC_SOURCE_CTRL_EXC_EN
   logic [1:0] cause_reg;
   logic [3:0] cnt_reg, cnt_next;
   logic       class_bad;
   logic       exc_detect;

   assign class_bad  = (op_class[2:1] == 2'b11);
   assign exc_detect = opcode_invalid | class_bad | overflow;
`else
   logic unused_exc_inputs;
   assign unused_exc_inputs = &{1'b0, overflow, opcode_invalid};
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         class_reg <= 3'd0;
         zero_reg  <= 1'b0;
         src_reg   <= 3'd0;
`ifdef PC_SOURCE_CTRL_EXC_EN
         cause_reg <= 2'b00;
         cnt_reg   <= 4'd0;
`endif
      end else begin
         state_reg <= state_next;
         src_reg   <= pc_source;
         if (state_reg == IDLE && instr_valid) begin
            class_reg <= op_class;
            zero_reg  <= alu_zero;
`ifdef PC_SOURCE_CTRL_EXC_EN
            // invalid opcode wins over overflow when both are flagged
            cause_reg <= (opcode_invalid || class_bad) ? 2'b00 : 2'b01;
`endif
         end
`ifdef PC_SOURCE_CTRL_EXC_EN
         cnt_reg <= cnt_next;
`endif
      end
   end

   // Normal-update mux select and load decision from the latched class
   always_comb begin
      upd_src = 3'd0;
      upd_pcw = 1'b1;
      case (class_reg)
         3'b001: begin upd_src = 3'd1; upd_pcw = zero_reg;  end
         3'b010: begin upd_src = 3'd1; upd_pcw = ~zero_reg; end
         3'b011: upd_src = 3'd2;
         3'b100: upd_src = 3'd3;
`ifdef PC_SOURCE_CTRL_EXC_EN
         3'b101: upd_src = 3'd4;
`endif
         default: upd_src = 3'd0;
      endcase
   end

   always_comb begin
      state_next  = state_reg;
      pc_source   = src_reg;
      pc_write    = 1'b0;
      epc_write   = 1'b0;
      cause_write = 1'b0;
      cause       = 2'b00;
      done        = 1'b0;
`ifdef PC_SOURCE_CTRL_EXC_EN
      cnt_next    = cnt_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (instr_valid) begin
`ifdef PC_SOURCE_CTRL_EXC_EN
               state_next = exc_detect ? EXC_SAVE : UPDATE;
`else
               state_next = UPDATE;
`endif
            end
         end
         UPDATE: begin
            pc_source  = upd_src;
            pc_write   = upd_pcw;
            done       = 1'b1;
            state_next = IDLE;
         end
`ifdef PC_SOURCE_CTRL_EXC_EN
         EXC_SAVE: begin
            epc_write   = 1'b1;
            cause_write = 1'b1;
            cause       = cause_reg;
            cnt_next    = 4'(MEM_WAIT);
            state_next  = EXC_WAIT;
         end
         EXC_WAIT: begin
            cnt_next = cnt_reg - 4'd1;
            if (cnt_reg <= 4'd1)
               state_next = EXC_LOAD;
         end
         EXC_LOAD: begin
            pc_source  = 3'd5;
            pc_write   = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_pc_source_ctrl.sv
// Bench for pc_source_ctrl (MEM_WAIT=3): vector table plus reset/busy corner sequences.
// Expectations follow whichever build of PC_SOURCE_CTRL_EXC_EN is compiled.
module tb_pc_source_ctrl;
   localparam int MW = 3;
`ifdef PC_SOURCE_CTRL_EXC_EN
   localparam bit EXC = 1'b1;
`else
   localparam bit EXC = 1'b0;
`endif

   logic       clk;
   logic       reset_n;
   logic       instr_valid;
   logic [2:0] op_class;
   logic       alu_zero;
   logic       overflow;
   logic       opcode_invalid;
   logic [2:0] pc_source;
   logic       pc_write;
   logic       epc_write;
   logic       cause_write;
   logic [1:0] cause;
   logic       busy;
   logic       done;

   pc_source_ctrl #(.MEM_WAIT(MW)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .instr_valid(instr_valid),
      .op_class(op_class),
      .alu_zero(alu_zero),
      .overflow(overflow),
      .opcode_invalid(opcode_invalid),
      .pc_source(pc_source),
      .pc_write(pc_write),
      .epc_write(epc_write),
      .cause_write(cause_write),
      .cause(cause),
      .busy(busy),
      .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] op;
      logic       z;
      logic       ovf;
      logic       inv;
      logic [2:0] e_src;
      logic       e_pcw;
      logic       e_epc;
      logic [1:0] e_cause;
      int         e_lat;
   } vec_t;

   vec_t tbl[13];
   vec_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   function automatic vec_t mk(input logic [2:0] op, input logic z, input logic ovf, input logic inv,
                               input logic [2:0] src, input logic pcw, input logic epc,
                               input logic [1:0] cs, input int lat);
      vec_t v;
      v.op = op; v.z = z; v.ovf = ovf; v.inv = inv;
      v.e_src = src; v.e_pcw = pcw; v.e_epc = epc; v.e_cause = cs; v.e_lat = lat;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      @(negedge clk);
      instr_valid    = 1'b1;
      op_class       = v.op;
      alu_zero       = v.z;
      overflow       = v.ovf;
      opcode_invalid = v.inv;
      sbq.push_back(v);
      @(negedge clk);
      instr_valid    = 1'b0;
      overflow       = 1'b0;
      opcode_invalid = 1'b0;
   endtask

   // poke>0: strobe instr_valid (class 011) for two cycles starting k=poke while busy
   task automatic run_txn(input vec_t v, input string tag, input int poke);
      int k, epc_k, epc_cnt, pcw_cnt;
      logic [1:0] epc_cause;
      vec_t e;
      drive(v);
      k = 1; epc_k = 0; epc_cnt = 0; pcw_cnt = 0; epc_cause = 2'b11;
      while (done !== 1'b1 && k < 40) begin
         if (epc_write === 1'b1) begin epc_cnt++; epc_k = k; epc_cause = cause; end
         if (pc_write === 1'b1) pcw_cnt++;
         if (poke > 0 && k == poke) begin instr_valid = 1'b1; op_class = 3'b011; end
         if (poke > 0 && k == poke + 2) instr_valid = 1'b0;
         @(negedge clk);
         k++;
      end
      instr_valid = 1'b0;
      op_class    = 3'b000;
      e = sbq.pop_front();
      chk({tag, " done"}, done, 1);
      chk({tag, " latency"}, k, e.e_lat);
      chk({tag, " pc_source"}, pc_source, e.e_src);
      chk({tag, " pc_write"}, pc_write, e.e_pcw);
      chk({tag, " busy_at_done"}, busy, 1);
      chk({tag, " early_pc_write"}, pcw_cnt, 0);
      chk({tag, " epc_count"}, epc_cnt, e.e_epc);
      if (e.e_epc) begin
         chk({tag, " epc_cycle"}, epc_k, 1);
         chk({tag, " cause"}, epc_cause, e.e_cause);
      end
      $display("txn %s: class=%0d src=%0d pcw=%0d lat=%0d epc=%0d", tag, v.op, pc_source, pc_write, k, epc_cnt);
      @(negedge clk);
      chk({tag, " busy_after"}, busy, 0);
      chk({tag, " pc_write_after"}, pc_write, 0);
      chk({tag, " epc_after"}, epc_write, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; instr_valid = 1'b0; op_class = 3'b000;
      alu_zero = 1'b0; overflow = 1'b0; opcode_invalid = 1'b0;

      tbl[0]  = mk(3'b000, 0, 0, 0, 3'd0, 1, 0, 2'b00, 1);
      tbl[1]  = mk(3'b001, 1, 0, 0, 3'd1, 1, 0, 2'b00, 1);
      tbl[2]  = mk(3'b001, 0, 0, 0, 3'd1, 0, 0, 2'b00, 1);
      tbl[3]  = mk(3'b010, 1, 0, 0, 3'd1, 0, 0, 2'b00, 1);
      tbl[4]  = mk(3'b010, 0, 0, 0, 3'd1, 1, 0, 2'b00, 1);
      tbl[5]  = mk(3'b011, 0, 0, 0, 3'd2, 1, 0, 2'b00, 1);
      tbl[6]  = mk(3'b100, 1, 0, 0, 3'd3, 1, 0, 2'b00, 1);
      tbl[7]  = EXC ? mk(3'b101, 0, 0, 0, 3'd4, 1, 0, 2'b00, 1)
                    : mk(3'b101, 0, 0, 0, 3'd0, 1, 0, 2'b00, 1);
      tbl[8]  = EXC ? mk(3'b000, 0, 1, 0, 3'd5, 1, 1, 2'b01, MW + 2)
                    : mk(3'b000, 0, 1, 0, 3'd0, 1, 0, 2'b00, 1);
      tbl[9]  = EXC ? mk(3'b011, 0, 0, 1, 3'd5, 1, 1, 2'b00, MW + 2)
                    : mk(3'b011, 0, 0, 1, 3'd2, 1, 0, 2'b00, 1);
      tbl[10] = EXC ? mk(3'b001, 1, 1, 1, 3'd5, 1, 1, 2'b00, MW + 2)
                    : mk(3'b001, 1, 1, 1, 3'd1, 1, 0, 2'b00, 1);
      tbl[11] = EXC ? mk(3'b110, 0, 0, 0, 3'd5, 1, 1, 2'b00, MW + 2)
                    : mk(3'b110, 0, 0, 0, 3'd0, 1, 0, 2'b00, 1);
      tbl[12] = EXC ? mk(3'b111, 0, 1, 0, 3'd5, 1, 1, 2'b00, MW + 2)
                    : mk(3'b111, 0, 1, 0, 3'd0, 1, 0, 2'b00, 1);

      // reset state
      repeat (3) @(negedge clk);
      chk("reset outputs", {pc_source, pc_write, epc_write, cause_write, cause, busy, done}, 0);
      reset_n = 1'b1;

      for (int i = 0; i < 13; i++)
         run_txn(tbl[i], $sformatf("vec%0d", i), 0);

      // strobes while busy must be dropped; invalid+overflow reports cause 00
      run_txn(EXC ? mk(3'b000, 0, 1, 1, 3'd5, 1, 1, 2'b00, MW + 2)
                  : mk(3'b000, 0, 1, 1, 3'd0, 1, 0, 2'b00, 1), "busy_poke", 2);

      // async reset in the middle of an exception wait
      run_txn(tbl[5], "pre_reset_jump", 0);
      @(negedge clk);
      instr_valid = 1'b1; op_class = 3'b100; overflow = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0; op_class = 3'b000; overflow = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset pc_source", pc_source, 0);
      chk("async_reset outputs", {pc_source, pc_write, epc_write, cause_write, cause, busy, done}, 0);
      $display("txn async_reset: src=%0d busy=%0d", pc_source, busy);
      @(negedge clk);
      chk("held_reset busy", busy, 0);
      reset_n = 1'b1;
      run_txn(mk(3'b011, 0, 0, 0, 3'd2, 1, 0, 2'b00, 1), "post_reset_jump", 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
